// File: rtl/logic_axi4_lite_bus_pkg.sv
// Shared types for the AXI4-Lite bus blocks.
// An address-map entry owns the half-open range [address_low, address_high).
package logic_axi4_lite_bus_pkg;

   typedef struct packed {
      logic [63:0] address_low;
      logic [63:0] address_high;
   } slave_t;

endpackage

// File: rtl/logic_axi4_lite_bus_slave_router_if.sv
// Upstream (s_*) and downstream (m_*) AXI4-Lite channels of the slave router.
// Valid/ready: a beat transfers on the rising edge where valid && ready; valid never waits on ready.
interface logic_axi4_lite_bus_slave_router_if #(
   parameter int SLAVES        = 2,
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_BYTES    = 4
);
   localparam int DW = 8 * DATA_BYTES;

   logic                     s_awvalid, s_awready;
   logic [ADDRESS_WIDTH-1:0] s_awaddr;
   logic [2:0]               s_awprot;
   logic                     s_wvalid, s_wready;
   logic [DW-1:0]            s_wdata;
   logic [DATA_BYTES-1:0]    s_wstrb;
   logic                     s_bvalid, s_bready;
   logic [1:0]               s_bresp;
   logic                     s_arvalid, s_arready;
   logic [ADDRESS_WIDTH-1:0] s_araddr;
   logic [2:0]               s_arprot;
   logic                     s_rvalid, s_rready;
   logic [DW-1:0]            s_rdata;
   logic [1:0]               s_rresp;

   logic [SLAVES-1:0]                    m_awvalid, m_awready;
   logic [SLAVES-1:0][ADDRESS_WIDTH-1:0] m_awaddr;
   logic [SLAVES-1:0][2:0]               m_awprot;
   logic [SLAVES-1:0]                    m_wvalid, m_wready;
   logic [SLAVES-1:0][DW-1:0]            m_wdata;
   logic [SLAVES-1:0][DATA_BYTES-1:0]    m_wstrb;
   logic [SLAVES-1:0]                    m_bvalid, m_bready;
   logic [SLAVES-1:0][1:0]               m_bresp;
   logic [SLAVES-1:0]                    m_arvalid, m_arready;
   logic [SLAVES-1:0][ADDRESS_WIDTH-1:0] m_araddr;
   logic [SLAVES-1:0][2:0]               m_arprot;
   logic [SLAVES-1:0]                    m_rvalid, m_rready;
   logic [SLAVES-1:0][DW-1:0]            m_rdata;
   logic [SLAVES-1:0][1:0]               m_rresp;

   modport slave (
      input  s_awvalid, s_awaddr, s_awprot, s_wvalid, s_wdata, s_wstrb, s_bready,
             s_arvalid, s_araddr, s_arprot, s_rready,
      output s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rdata, s_rresp,
      output m_awvalid, m_awaddr, m_awprot, m_wvalid, m_wdata, m_wstrb, m_bready,
             m_arvalid, m_araddr, m_arprot, m_rready,
      input  m_awready, m_wready, m_bvalid, m_bresp, m_arready, m_rvalid, m_rdata, m_rresp
   );

   modport master (
      output s_awvalid, s_awaddr, s_awprot, s_wvalid, s_wdata, s_wstrb, s_bready,
             s_arvalid, s_araddr, s_arprot, s_rready,
      input  s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rdata, s_rresp,
      input  m_awvalid, m_awaddr, m_awprot, m_wvalid, m_wdata, m_wstrb, m_bready,
             m_arvalid, m_araddr, m_arprot, m_rready,
      output m_awready, m_wready, m_bvalid, m_bresp, m_arready, m_rvalid, m_rdata, m_rresp
   );
endinterface

// File: rtl/logic_axi4_lite_bus_slave_router.sv
// AXI4-Lite 1-to-SLAVES address router with in-order response return per direction.
// Unmapped accesses never leave the block: they are answered with DECERR from the order FIFO.
module logic_axi4_lite_bus_slave_router
   import logic_axi4_lite_bus_pkg::*;
#(
   parameter int SLAVES        = 2,
   parameter int SLAVES_WIDTH  = (SLAVES >= 2) ? $clog2(SLAVES) : 1,
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_BYTES    = 4,
   parameter int OUTSTANDING   = 4,
   parameter slave_t [SLAVES-1:0] MAP = '0
) (
   input logic aclk,
   input logic areset_n,
   logic_axi4_lite_bus_slave_router_if.slave bus
);
   localparam int DW = 8 * DATA_BYTES;
   localparam int PW = (OUTSTANDING >= 2) ? $clog2(OUTSTANDING) : 1;
   localparam int CW = $clog2(OUTSTANDING + 1);

   typedef struct packed {
      logic                    mapped;
      logic [SLAVES_WIDTH-1:0] id;
   } dec_t;

   // Ascending scan so the highest overlapping index wins.
   function automatic dec_t decode(input logic [ADDRESS_WIDTH-1:0] a);
      dec_t d;
      logic [ADDRESS_WIDTH-1:0] lo, hi;
      d = '0;
      for (int k = 0; k < SLAVES; k++) begin
         lo = MAP[k].address_low[ADDRESS_WIDTH-1:0];
         hi = MAP[k].address_high[ADDRESS_WIDTH-1:0];
         if (a >= lo && a < hi) begin
            d.mapped = 1'b1;
            d.id     = SLAVES_WIDTH'(k);
         end
      end
      return d;
   endfunction

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
   endfunction

   // ---------------- write path ----------------
   logic                     aw_pend, w_pend, aw_done, w_done;
   logic [SLAVES_WIDTH-1:0]  w_target;
   logic [ADDRESS_WIDTH-1:0] aw_addr_q;
   logic [2:0]               aw_prot_q;
   logic [DW-1:0]            w_data_q;
   logic [DATA_BYTES-1:0]    w_strb_q;
   dec_t                     wfifo [OUTSTANDING];
   logic [PW-1:0]            w_wr_ptr, w_rd_ptr;
   logic [CW-1:0]            wcount;
   dec_t                     w_dec, w_head;
   logic                     w_accept, w_pop;

   assign w_dec    = decode(bus.s_awaddr);
   assign w_head   = wfifo[w_rd_ptr];
   assign w_accept = areset_n && bus.s_awvalid && bus.s_wvalid && !aw_pend && !w_pend
                     && (wcount < CW'(OUTSTANDING));
   assign aw_done  = |(bus.m_awvalid & bus.m_awready);
   assign w_done   = |(bus.m_wvalid & bus.m_wready);
   assign w_pop    = bus.s_bvalid && bus.s_bready;

   always_comb begin
      bus.s_awready = w_accept;
      bus.s_wready  = w_accept;
      bus.s_bvalid  = 1'b0;
      bus.s_bresp   = 2'b00;
      bus.m_awvalid = '0;
      bus.m_wvalid  = '0;
      bus.m_bready  = '0;
      bus.m_awaddr  = '0;
      bus.m_awprot  = '0;
      bus.m_wdata   = '0;
      bus.m_wstrb   = '0;
      for (int k = 0; k < SLAVES; k++) begin
         bus.m_awvalid[k] = aw_pend && (w_target == SLAVES_WIDTH'(k));
         bus.m_wvalid[k]  = w_pend && (w_target == SLAVES_WIDTH'(k));
         bus.m_awaddr[k]  = aw_addr_q;
         bus.m_awprot[k]  = aw_prot_q;
         bus.m_wdata[k]   = w_data_q;
         bus.m_wstrb[k]   = w_strb_q;
         if (wcount != '0 && w_head.mapped && w_head.id == SLAVES_WIDTH'(k)) begin
            bus.s_bvalid    = bus.m_bvalid[k];
            bus.s_bresp     = bus.m_bresp[k];
            bus.m_bready[k] = bus.s_bready;
         end
      end
      if (wcount != '0 && !w_head.mapped) begin
         bus.s_bvalid = 1'b1;
         bus.s_bresp  = 2'b11;
      end
   end

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         aw_pend  <= 1'b0;
         w_pend   <= 1'b0;
         w_target <= '0;
         w_wr_ptr <= '0;
         w_rd_ptr <= '0;
         wcount   <= '0;
      end else begin
         if (w_accept) begin
            w_wr_ptr <= ptr_inc(w_wr_ptr);
            if (w_dec.mapped) begin
               aw_pend  <= 1'b1;
               w_pend   <= 1'b1;
               w_target <= w_dec.id;
            end
         end else begin
            if (aw_done) aw_pend <= 1'b0;
            if (w_done)  w_pend  <= 1'b0;
         end
         if (w_pop) w_rd_ptr <= ptr_inc(w_rd_ptr);
         if (w_accept && !w_pop)      wcount <= wcount + 1'b1;
         else if (!w_accept && w_pop) wcount <= wcount - 1'b1;
      end
   end

   always_ff @(posedge aclk) begin
      if (w_accept) begin
         wfifo[w_wr_ptr] <= w_dec;
         if (w_dec.mapped) begin
            aw_addr_q <= bus.s_awaddr;
            aw_prot_q <= bus.s_awprot;
            w_data_q  <= bus.s_wdata;
            w_strb_q  <= bus.s_wstrb;
         end
      end
   end

   // ---------------- read path ----------------
   logic                     ar_pend, ar_done;
   logic [SLAVES_WIDTH-1:0]  r_target;
   logic [ADDRESS_WIDTH-1:0] ar_addr_q;
   logic [2:0]               ar_prot_q;
   dec_t                     rfifo [OUTSTANDING];
   logic [PW-1:0]            r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]            rcount;
   dec_t                     r_dec, r_head;
   logic                     r_accept, r_pop;

   assign r_dec    = decode(bus.s_araddr);
   assign r_head   = rfifo[r_rd_ptr];
   assign r_accept = areset_n && bus.s_arvalid && !ar_pend && (rcount < CW'(OUTSTANDING));
   assign ar_done  = |(bus.m_arvalid & bus.m_arready);
   assign r_pop    = bus.s_rvalid && bus.s_rready;

   always_comb begin
      bus.s_arready = r_accept;
      bus.s_rvalid  = 1'b0;
      bus.s_rdata   = '0;
      bus.s_rresp   = 2'b00;
      bus.m_arvalid = '0;
      bus.m_rready  = '0;
      bus.m_araddr  = '0;
      bus.m_arprot  = '0;
      for (int k = 0; k < SLAVES; k++) begin
         bus.m_arvalid[k] = ar_pend && (r_target == SLAVES_WIDTH'(k));
         bus.m_araddr[k]  = ar_addr_q;
         bus.m_arprot[k]  = ar_prot_q;
         if (rcount != '0 && r_head.mapped && r_head.id == SLAVES_WIDTH'(k)) begin
            bus.s_rvalid    = bus.m_rvalid[k];
            bus.s_rdata     = bus.m_rdata[k];
            bus.s_rresp     = bus.m_rresp[k];
            bus.m_rready[k] = bus.s_rready;
         end
      end
      if (rcount != '0 && !r_head.mapped) begin
         bus.s_rvalid = 1'b1;
         bus.s_rresp  = 2'b11;
      end
   end

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         ar_pend  <= 1'b0;
         r_target <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         rcount   <= '0;
      end else begin
         if (r_accept) begin
            r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (r_dec.mapped) begin
               ar_pend  <= 1'b1;
               r_target <= r_dec.id;
            end
         end else if (ar_done) begin
            ar_pend <= 1'b0;
         end
         if (r_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
         if (r_accept && !r_pop)      rcount <= rcount + 1'b1;
         else if (!r_accept && r_pop) rcount <= rcount - 1'b1;
      end
   end

   always_ff @(posedge aclk) begin
      if (r_accept) begin
         rfifo[r_wr_ptr] <= r_dec;
         if (r_dec.mapped) begin
            ar_addr_q <= bus.s_araddr;
            ar_prot_q <= bus.s_arprot;
         end
      end
   end

endmodule
